// File: rtl/s3g_pkg.sv
// Shared constants for the S3G receive path: packet start byte, UART state
// encoding, default baud divider and a 3-input majority helper.
package s3g_pkg;

  localparam logic [7:0] S3G_START = 8'hD5;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  // 50 MHz system clock, 115200 baud
  localparam int UART_BAUD_DIV = 434;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_START = START,
    ST_DATA  = DATA,
    ST_STOP  = STOP,
    ST_BREAK = BREAK
  } uart_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte stream and status out.
interface uart_rx_if;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  modport master (output rx_in, input rx_data, input rx_done, input frame_err, input busy);
  modport slave  (input rx_in, output rx_data, output rx_done, output frame_err, output busy);
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 (idle level).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= 1'b1;
      q_reg    <= 1'b1;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 3-sample majority vote per bit, framing-error
// reporting and break handling. Feeds the S3G packet parser.
module uart_rx
  import s3g_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV,
  parameter int CNT_W    = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int HALF = BAUD_DIV / 2;
  localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HM1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_H    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_HP1  = CNT_W'(HALF + 1);

  logic             rxs;
  uart_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bitidx_reg, bitidx_next;
  logic [7:0]       shreg_reg, shreg_next;
  logic             samp_a_reg, samp_a_next;
  logic             samp_b_reg, samp_b_next;
  logic [7:0]       rx_data_reg, rx_data_next;
  logic             rx_done_reg, rx_done_next;
  logic             frame_err_reg, frame_err_next;
  logic             at_wrap, decide, vote;

  sync2 u_sync (.clk(clk), .rst(rst), .d(bus.rx_in), .q(rxs));

  assign at_wrap = (cnt_reg == CNT_WRAP);
  assign decide  = (cnt_reg == CNT_HP1);
  assign vote    = maj3(samp_a_reg, samp_b_reg, rxs);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      bitidx_reg    <= '0;
      shreg_reg     <= '0;
      samp_a_reg    <= 1'b1;
      samp_b_reg    <= 1'b1;
      rx_data_reg   <= '0;
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bitidx_reg    <= bitidx_next;
      shreg_reg     <= shreg_next;
      samp_a_reg    <= samp_a_next;
      samp_b_reg    <= samp_b_next;
      rx_data_reg   <= rx_data_next;
      rx_done_reg   <= rx_done_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bitidx_next    = bitidx_reg;
    shreg_next     = shreg_reg;
    samp_a_next    = samp_a_reg;
    samp_b_next    = samp_b_reg;
    rx_data_next   = rx_data_reg;
    rx_done_next   = 1'b0;
    frame_err_next = 1'b0;

    // Bit-period counter and early samples run only while inside a frame
    if (state_reg == ST_START || state_reg == ST_DATA || state_reg == ST_STOP) begin
      cnt_next = at_wrap ? '0 : cnt_reg + 1'b1;
      if (cnt_reg == CNT_HM1) samp_a_next = rxs;
      if (cnt_reg == CNT_H)   samp_b_next = rxs;
    end

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (!rxs) state_next = ST_START;
      end
      ST_START: begin
        if (decide && vote) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (at_wrap) begin
          state_next  = ST_DATA;
          bitidx_next = '0;
        end
      end
      ST_DATA: begin
        if (decide) shreg_next = {vote, shreg_reg[7:1]};
        if (at_wrap) begin
          if (bitidx_reg == 3'd7) state_next = ST_STOP;
          else                    bitidx_next = bitidx_reg + 3'd1;
        end
      end
      ST_STOP: begin
        // Leave mid stop bit so an immediately following start bit is caught
        if (decide) begin
          cnt_next = '0;
          if (vote) begin
            rx_data_next = shreg_reg;
            rx_done_next = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_next = '0;
        if (rxs) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_done   = rx_done_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at BAUD_DIV=16: stimulus pushes the
// expected event per frame, a monitor pops and compares on each strobe.
module tb_uart_rx;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(.BAUD_DIV(BD), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // bit 8 set: framing error expected; otherwise a good byte in bits 7:0
  logic [8:0] exp_q[$];
  logic [7:0] last_good;
  logic       prev_done;
  bit         busy_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      last_good = 8'h00;
      prev_done = 1'b0;
    end else begin
      logic [8:0] e;
      if (bus.busy) busy_seen = 1'b1;
      if (prev_done) check("done_one_cycle", {31'd0, bus.rx_done}, 32'd0);
      if (bus.rx_done || bus.frame_err) begin
        check("never_both", {31'd0, bus.rx_done & bus.frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {23'd0, bus.frame_err, bus.rx_data}, 32'h1FF);
        end else begin
          e = exp_q.pop_front();
          if (e[8]) begin
            check("frame_err_event", {23'd0, bus.frame_err, bus.rx_data}, {23'd0, 1'b1, last_good});
          end else begin
            check("rx_byte", {23'd0, bus.frame_err, bus.rx_data}, {23'd0, 1'b0, e[7:0]});
            last_good = e[7:0];
          end
        end
      end
      prev_done = bus.rx_done;
    end
  end

  task automatic drive_bit(input logic v);
    bus.rx_in = v;
    repeat (BD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap, input int glitch_bit);
    exp_q.push_back(stop ? {1'b0, b} : 9'h100);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit && !b[i]) begin
        bus.rx_in = 1'b0; repeat (9) @(negedge clk);
        bus.rx_in = 1'b1; @(negedge clk);
        bus.rx_in = 1'b0; repeat (BD - 10) @(negedge clk);
      end else begin
        drive_bit(b[i]);
      end
    end
    drive_bit(stop);
    bus.rx_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [31:0] outs();
    return {21'd0, bus.rx_data, bus.rx_done, bus.frame_err, bus.busy};
  endfunction

  initial begin
    logic [7:0] b2b [5];
    logic [7:0] rb;
    logic       rs;
    int         gap;
    b2b = '{8'h03, 8'h01, 8'h02, 8'h03, 8'hCC};

    bus.rx_in = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_release_outputs", outs(), 32'd0);

    // Nominal 0xD5
    busy_seen = 1'b0;
    send_frame(8'hD5, 1'b1, BD, -1);
    check("d5_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("d5_busy_after", {31'd0, bus.busy}, 32'd0);
    check("d5_drained", exp_q.size(), 32'd0);

    // Back-to-back, zero idle gap
    for (int i = 0; i < 5; i++) send_frame(b2b[i], 1'b1, (i == 4) ? BD : 0, -1);
    check("b2b_drained", exp_q.size(), 32'd0);
    check("b2b_last", {24'd0, bus.rx_data}, 32'hCC);

    // 3-cycle low pulse on idle line: false start
    busy_seen = 1'b0;
    bus.rx_in = 1'b0; repeat (3) @(negedge clk);
    bus.rx_in = 1'b1; repeat (3 * BD) @(negedge clk);
    check("pulse_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("pulse_busy_after", {31'd0, bus.busy}, 32'd0);
    check("pulse_rx_data", {24'd0, bus.rx_data}, 32'hCC);

    // Stop bit low
    send_frame(8'h55, 1'b0, BD, -1);
    check("ferr_drained", exp_q.size(), 32'd0);
    check("ferr_rx_data_held", {24'd0, bus.rx_data}, 32'hCC);

    // Line held low for 40 bit periods: one framing error, then a clean frame
    exp_q.push_back(9'h100);
    bus.rx_in = 1'b0; repeat (40 * BD) @(negedge clk);
    bus.rx_in = 1'b1; repeat (BD) @(negedge clk);
    check("break_busy_after", {31'd0, bus.busy}, 32'd0);
    send_frame(8'h01, 1'b1, BD, -1);
    check("break_recover", {24'd0, bus.rx_data}, 32'h01);

    // Reset during bit 4 of a frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    bus.rx_in = 1'b1;
    repeat (BD / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midframe_reset_outputs", outs(), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2 * BD) @(negedge clk);
    check("midframe_after_release", outs(), 32'd0);
    send_frame(8'hA5, 1'b1, BD, -1);
    check("midframe_next_byte", {24'd0, bus.rx_data}, 32'hA5);

    // One-cycle high glitch inside a 0 data bit
    send_frame(8'hA0, 1'b1, BD, 0);
    send_frame(8'h5A, 1'b1, BD, 7);
    check("glitch_drained", exp_q.size(), 32'd0);

    // Randomized frames against the scoreboard
    for (int i = 0; i < 30; i++) begin
      rb  = 8'($urandom);
      rs  = ($urandom_range(0, 4) != 0);
      gap = rs ? $urandom_range(0, 20) : $urandom_range(BD, 2 * BD);
      send_frame(rb, rs, gap, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1);
    end

    repeat (3 * BD) @(negedge clk);
    check("final_drained", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver sitting directly upstream of s3g_rx.
- Converts the asynchronous host RX line (8N1, LSB first) into the byte stream s3g_rx consumes: `rx_data` plus a one-cycle `rx_done` strobe per byte.
- Also flags framing errors and reports line activity, so upper layers can resync the S3G packet parser.

Parameters:
- BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range 8..65535.
- CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > BAUD_DIV.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset. rst=0 resets immediately; release is sampled on clk.
- rx_in  in  1  raw serial line, asynchronous to clk, idle high.
- rx_data  out  8  last correctly received byte; held until the next good byte.
- rx_done  out  1  one-cycle strobe; rx_data is valid in the same cycle.
- frame_err  out  1  one-cycle strobe when the stop bit is sampled low.
- busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset values:
  - rx_data=8'h00, rx_done=0, frame_err=0, busy=0.
  - Synchronizer flops = 1, state=IDLE, counters=0.
- Input path:
  - rx_in passes through a 2-flop synchronizer giving `rxs`.
  - All decisions use rxs only.
- Bit counter:
  - cnt runs 0..BAUD_DIV-1 and wraps to 0; H = BAUD_DIV/2 (integer division).
- Majority sampling:
  - Sample rxs at cnt = H-1, H and H+1.
  - The bit value is the majority of the three, decided at cnt = H+1.
- States:
  - IDLE: busy=0. When rxs=0: cnt<=0, go to START, busy=1 from the next cycle.
  - START: at decision point, a majority of 1 is a false start; go to IDLE with no strobe. Majority 0: continue counting; at wrap go to DATA with bitidx=0.
  - DATA: at each decision point, shift the majority into shreg[7] (LSB first; after 8 bits, shreg[0] holds bit 0). At wrap after bitidx=7 go to STOP, otherwise bitidx++.
  - STOP, decision point with majority 1:
    - rx_data<=shreg and rx_done=1 for exactly this one cycle.
    - Go to IDLE immediately (mid stop bit), so a start bit straight after the stop bit is caught.
  - STOP, decision point with majority 0:
    - frame_err=1 for one cycle; rx_data unchanged; no rx_done.
    - Go to BREAK.
  - BREAK: busy=1; wait until rxs=1, then go to IDLE. A line held low reports exactly one frame_err.
- Latency:
  - rx_done rises 2 + 9*BAUD_DIV + H + 1 cycles (±1 from synchronizer phase) after the rx_in falling edge.
  - BAUD_DIV=16: about 155 cycles.
- rx_done and frame_err are never high together; each stays high for one cycle only.
- Back-to-back frames (no idle gap) are received without loss.
- Glitch rejection:
  - A low pulse shorter than 2 cycles that misses two of the three samples is rejected at START.
  - A 1-cycle glitch inside a data bit is filtered by the majority vote.
- Reset mid-frame: everything returns to reset values at once; the partial byte is discarded; no strobe after release.
- rx_in going low during reset: after release a new frame starts only on rxs=0 while in IDLE. Any frame already in flight resolves as a false start or a framing error.

Decomposition:
- Shared package s3g_pkg:
  - S3G_START = 8'hD5.
  - UART state encoding localparams IDLE/START/DATA/STOP/BREAK (3 bits).
  - Default BAUD_DIV constant.
- Sub-module sync2: 2-flop synchronizer with async active-low reset value 1. It is reused by the other asynchronous inputs in the design.
- Majority vote and counters stay inline.

Test Plan:
- BAUD_DIV=16, send 0xD5 with nominal timing: rx_data=8'hD5, rx_done high exactly one cycle, frame_err never high, busy low afterwards.
- Back-to-back 0x03, 0x01, 0x02, 0x03, 0xCC with zero idle gap: five rx_done strobes, bytes in order, none lost.
- Low pulse of 3 cycles on idle line: busy pulses, then returns to IDLE; no rx_done, no frame_err.
- Send 0x55 with stop bit driven low, then line high: frame_err one cycle, no rx_done, rx_data keeps its previous value (0xCC).
- Hold rx_in low for 40 bit periods: exactly one frame_err; next normal 0x01 frame is received correctly.
- Assert rst during bit 4 of a byte, release after 5 cycles with line idle: all outputs 0, no strobe; next frame 0xA5 is received as 0xA5.
- Optional extra, same bench: 1-cycle high glitch at cnt=H of a 0 data bit leaves the byte uncorrupted.
